// File: rtl/fib_index_finder_if.sv
// fib_index_finder_if: lookup request/result bundle between a requester and the Fibonacci index finder.
interface fib_index_finder_if;
    logic       start;
    logic [7:0] target;
    logic       busy;
    logic       done;
    logic       is_fib;
    logic [3:0] index;
    modport master (output start, target, input busy, done, is_fib, index);
    modport slave  (input start, target, output busy, done, is_fib, index);
endinterface

// File: rtl/fib_index_finder.sv
// fib_index_finder: walks the Fibonacci sequence until it meets or passes the captured target,
// reporting whether the target is a Fibonacci number and its smallest index.
module fib_index_finder (
    input  logic                  clk,
    input  logic                  rst_n,
    fib_index_finder_if.slave     bus
);
    typedef enum logic {IDLE, CALC} state_t;
    state_t     state_q, state_d;
    logic [7:0] target_q, target_d;
    logic [9:0] a_q, a_d, b_q, b_d;
    logic [3:0] n_q, n_d;
    logic       done_q, done_d;
    logic       is_fib_q, is_fib_d;
    logic [3:0] index_q, index_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            done_q   <= 1'b0;
            is_fib_q <= 1'b0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            done_q   <= done_d;
            is_fib_q <= is_fib_d;
            index_q  <= index_d;
        end
    end
    // a is 10 bits so F(14)=377 overshoots any 8-bit target without wrapping
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        done_d   = 1'b0;
        is_fib_d = is_fib_q;
        index_d  = index_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d  = CALC;
                target_d = bus.target;
                a_d      = 10'd0;
                b_d      = 10'd1;
                n_d      = 4'd0;
                is_fib_d = 1'b0;
                index_d  = 4'd0;
            end
        end else if (a_q == {2'b00, target_q}) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            is_fib_d = 1'b1;
            index_d  = n_q;
        end else if (a_q > {2'b00, target_q}) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            is_fib_d = 1'b0;
            index_d  = 4'd0;
        end else begin
            a_d = b_q;
            b_d = a_q + b_q;
            n_d = n_q + 4'd1;
        end
    end
    assign bus.busy   = (state_q == CALC);
    assign bus.done   = done_q;
    assign bus.is_fib = is_fib_q;
    assign bus.index  = index_q;
endmodule

// File: tb/tb_fib_index_finder.sv
// tb_fib_index_finder: directed lookups; expected results and completion cycles go into a
// scoreboard queue that a done-triggered monitor drains.
module tb_fib_index_finder;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    typedef struct {
        logic       f;
        logic [3:0] idx;
        int         cyc;
    } exp_t;
    exp_t sb[$];
    fib_index_finder_if bus ();
    fib_index_finder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    // monitor: each done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("is_fib", int'(bus.is_fib), int'(e.f));
                chk("index", int'(bus.index), int'(e.idx));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end
    // called at a negedge; lat is the edge count from the accepting edge to completion
    task automatic issue(input logic [7:0] tgt, input logic f, input logic [3:0] idx, input int lat);
        exp_t e;
        e.f   = f;
        e.idx = idx;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        bus.start  = 1'b1;
        bus.target = tgt;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask
    task automatic wait_done();
        int i = 0;
        while (!bus.done && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask
    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.target = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_is_fib", int'(bus.is_fib), 0);
        chk("rst_index", int'(bus.index), 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'd0, 1'b1, 4'd0, 1);
        chk("busy_after_e0", int'(bus.busy), 1);
        wait_done();
        chk("busy_in_done", int'(bus.busy), 0);
        @(negedge clk);
        chk("done_one_cycle", int'(bus.done), 0);
        chk("hold_is_fib", int'(bus.is_fib), 1);
        issue(8'd1, 1'b1, 4'd1, 2);
        wait_done();
        @(negedge clk);
        issue(8'd233, 1'b1, 4'd13, 14);
        wait_done();
        issue(8'd4, 1'b0, 4'd0, 6);
        chk("b2b_busy", int'(bus.busy), 1);
        wait_done();
        @(negedge clk);
        issue(8'd255, 1'b0, 4'd0, 15);
        wait_done();
        @(negedge clk);
        issue(8'd21, 1'b1, 4'd8, 9);
        repeat (2) @(negedge clk);
        bus.start  = 1'b1;
        bus.target = 8'd8;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done();
        @(negedge clk);
        issue(8'd100, 1'b0, 4'd0, 13);
        wait_done();
        @(negedge clk);
        issue(8'd144, 1'b1, 4'd12, 13);
        wait_done();
        @(negedge clk);
        chk("hold_index", int'(bus.index), 12);
        bus.start  = 1'b1;
        bus.target = 8'd233;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (3) @(negedge clk);
        chk("calc_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", int'(bus.busy), 0);
        chk("async_done", int'(bus.done), 0);
        chk("async_is_fib", int'(bus.is_fib), 0);
        chk("async_index", int'(bus.index), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(8'd13, 1'b1, 4'd7, 8);
        wait_done();
        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
